// File: rtl/map_demux_pkg.sv
// Shared channel codes and sizes for the byte demux router.
// Same select encoding as the core's 4:1 byte selector.
package map_demux_pkg;

   localparam int BYTE_W = 8;
   localparam int NUM_CH = 4;

   typedef enum logic [1:0] {
      CH_X1 = 2'b00,
      CH_X2 = 2'b01,
      CH_X3 = 2'b10,
      CH_X4 = 2'b11
   } ch_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry byte holding slot with valid/ready drain.
// Optional delivery counter under DEMUX_CNT_EN.
module demux_slot
   import map_demux_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              LOAD,
   input  logic [BYTE_W-1:0] DIN,
   input  logic              RDY,
   output logic [BYTE_W-1:0] DOUT,
   output logic              VLD
`ifdef DEMUX_CNT_EN
   ,
   output logic [7:0]        CNT
`endif
);

   logic drain;

   assign drain = VLD & RDY;

   // A load in the same cycle as a drain overwrites without a bubble.
   always_ff @(posedge CLK) begin
      if (RST) begin
         VLD  <= 1'b0;
         DOUT <= '0;
      end else if (LOAD) begin
         VLD  <= 1'b1;
         DOUT <= DIN;
      end else if (drain) begin
         VLD  <= 1'b0;
      end
   end

`ifdef DEMUX_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST)
         CNT <= 8'h00;
      else if (drain)
         CNT <= CNT + 8'h01;
   end
`endif

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-4 byte demux with per-channel valid/ready slots.
// Define DEMUX_CNT_EN to enable the per-channel drain counters on CNT.
module demux_router
   import map_demux_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  SEL,
   input  logic [7:0]  D,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic [7:0]  X1,
   output logic [7:0]  X2,
   output logic [7:0]  X3,
   output logic [7:0]  X4,
   output logic [3:0]  V,
   input  logic [3:0]  R,
   output logic [31:0] CNT
);

   logic [NUM_CH-1:0] sel_oh;
   logic [NUM_CH-1:0] load;
   logic [BYTE_W-1:0] x [NUM_CH];

   always_comb begin
      sel_oh = '0;
      unique case (ch_e'(SEL))
         CH_X1: sel_oh = 4'b0001;
         CH_X2: sel_oh = 4'b0010;
         CH_X3: sel_oh = 4'b0100;
         CH_X4: sel_oh = 4'b1000;
      endcase
   end

   // Only the addressed slot gates acceptance.
   assign IN_READY = ~V[SEL] | R[SEL];
   assign load     = sel_oh & {NUM_CH{IN_VALID & IN_READY}};

`ifdef DEMUX_CNT_EN
   logic [7:0] cnt [NUM_CH];
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_slot u_slot (
         .CLK  (CLK),
         .RST  (RST),
         .LOAD (load[i]),
         .DIN  (D),
         .RDY  (R[i]),
         .DOUT (x[i]),
         .VLD  (V[i])
`ifdef DEMUX_CNT_EN
         ,
         .CNT  (cnt[i])
`endif
      );
   end

   assign X1 = x[0];
   assign X2 = x[1];
   assign X3 = x[2];
   assign X4 = x[3];

`ifdef DEMUX_CNT_EN
   assign CNT = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
   assign CNT = 32'h0;
`endif

endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: per-channel queues of held bytes.
module tb_demux_router;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = 2'b00;
   logic [7:0]  d = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  x1, x2, x3, x4;
   logic [3:0]  v;
   logic [3:0]  r = 4'b0000;
   logic [31:0] cnt_o;

   int total = 0;
   int bad = 0;

   logic [7:0] q [4][$];
   logic [7:0] last [4];
   logic [7:0] cntm [4];
   logic       exp_ready = 1'b1;
   logic       armed = 1'b0;

   always #5 clk = ~clk;

   demux_router dut (
      .CLK      (clk),
      .RST      (rst),
      .SEL      (sel),
      .D        (d),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .X1       (x1),
      .X2       (x2),
      .X3       (x3),
      .X4       (x4),
      .V        (v),
      .R        (r),
      .CNT      (cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic logic [7:0] xsel(input int i);
      case (i)
         0: return x1;
         1: return x2;
         2: return x3;
         default: return x4;
      endcase
   endfunction

   // Monitor: compare DUT state to the model, pop drained bytes.
   always @(negedge clk) begin
      if (armed) begin
         logic [31:0] ecnt;
         chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("v%0d", i), {31'b0, v[i]},
                {31'b0, q[i].size() != 0});
            chk($sformatf("x%0d", i), {24'b0, xsel(i)}, {24'b0, last[i]});
            if (q[i].size() != 0 && r[i]) begin
               logic [7:0] b;
               b = q[i].pop_front();
               chk($sformatf("drain%0d", i), {24'b0, xsel(i)}, {24'b0, b});
               cntm[i] = cntm[i] + 8'h01;
            end
         end
`ifdef DEMUX_CNT_EN
         ecnt = {cntm[3], cntm[2], cntm[1], cntm[0]};
`else
         ecnt = 32'h0;
`endif
         chk("cnt", cnt_o, ecnt);
      end
   end

   // One cycle of stimulus; expected bytes are pushed after the monitor.
   task automatic drive(input logic rs, input logic iv, input logic [1:0] s,
                        input logic [7:0] dd, input logic [3:0] rr);
      @(posedge clk);
      #1;
      rst = rs;
      in_valid = iv;
      sel = s;
      d = dd;
      r = rr;
      exp_ready = (q[s].size() == 0) || rr[s];
      @(negedge clk);
      #1;
      if (rs) begin
         for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last[i] = 8'h00;
            cntm[i] = 8'h00;
         end
         armed = 1'b1;
      end else if (iv && exp_ready) begin
         q[s].push_back(dd);
         last[s] = dd;
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         last[i] = 8'h00;
         cntm[i] = 8'h00;
      end

      drive(1, 0, 2'b00, 8'h00, 4'b0000);
      drive(1, 0, 2'b00, 8'h00, 4'b0000);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("rst_v", {28'b0, v}, 32'h0);
      chk("rst_rdy", {31'b0, in_ready}, 32'h1);

      drive(0, 1, 2'b10, 8'hA5, 4'b0000);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("steer_x3", {24'b0, x3}, 32'hA5);
      drive(0, 0, 2'b00, 8'h00, 4'b0100);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("steer_v", {28'b0, v}, 32'h0);

      drive(0, 1, 2'b00, 8'h11, 4'b0000);
      drive(0, 1, 2'b00, 8'h22, 4'b0000);
      chk("bp_x1", {24'b0, x1}, 32'h11);
      drive(0, 1, 2'b01, 8'h33, 4'b0000);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("bp_v", {28'b0, v}, 32'h3);
      drive(0, 0, 2'b00, 8'h00, 4'b1111);

      drive(0, 1, 2'b11, 8'h40, 4'b0000);
      for (int b = 8'h41; b <= 8'h44; b++)
         drive(0, 1, 2'b11, 8'(b), 4'b1000);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("b2b_x4", {24'b0, x4}, 32'h44);
      drive(0, 0, 2'b00, 8'h00, 4'b1111);

      for (int i = 0; i < 4; i++)
         drive(0, 1, 2'(i), 8'(8'hC0 + i), 4'b0000);
      drive(1, 1, 2'b10, 8'hEE, 4'b0000);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("rst_mid_v", {28'b0, v}, 32'h0);
      chk("rst_mid_x3", {24'b0, x3}, 32'h0);

      drive(1, 0, 2'b00, 8'h00, 4'b0000);
      for (int i = 0; i < 257; i++)
         drive(0, 1, 2'b01, 8'(i), 4'b0010);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);
      chk("cnt_wrap", cnt_o, 32'h0);

      for (int n = 0; n < 2000; n++) begin
         drive(($urandom_range(0, 99) == 0), 1'($urandom),
               2'($urandom), 8'($urandom), 4'($urandom));
      end
      drive(0, 0, 2'b00, 8'h00, 4'b1111);
      drive(0, 0, 2'b00, 8'h00, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
